// File: rtl/mux_scan_sequencer.sv
// Channel-scan sequencer for a 16:1 mux: steps Sel through 0..LastCh, captures each
// channel's data and offers it downstream on a valid/ready handshake tagged with its channel.
module mux_scan_sequencer #(
    parameter int unsigned CH_BITS = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DWELL_W = 24
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Enable,
    input  logic               Mode,
    input  logic               Step,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic [CH_BITS-1:0] LastCh,
    input  logic [DATA_W-1:0]  MuxData,
    output logic [CH_BITS-1:0] Sel,
    output logic [DATA_W-1:0]  SampleData,
    output logic [CH_BITS-1:0] SampleCh,
    output logic               SampleValid,
    input  logic               SampleReady,
    output logic               Wrap
);

    typedef enum logic [1:0] {IDLE, SETTLE, OFFER, DWELL} state_t;

    state_t             state;
    state_t             state_next;
    logic [DWELL_W-1:0] count;
    logic               advance;
    logic               accept;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Auto advance fires once the count has run down to zero, so DWELL lasts
    // max(Dwell,1)+1 cycles and a channel takes Dwell+3 cycles with Ready tied high.
    always_comb begin
        state_next = state;
        advance    = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (Enable) state_next = SETTLE;
            end
            SETTLE: begin
                state_next = OFFER;
            end
            OFFER: begin
                if (SampleReady) begin
                    accept     = 1'b1;
                    state_next = DWELL;
                end
            end
            DWELL: begin
                if (!Enable) begin
                    state_next = IDLE;
                end else if (Mode ? Step : (count == '0)) begin
                    advance    = 1'b1;
                    state_next = SETTLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        SampleValid = (state == OFFER);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Sel        <= '0;
            SampleData <= '0;
            SampleCh   <= '0;
            Wrap       <= 1'b0;
            count      <= '0;
        end else begin
            Wrap <= 1'b0;

            if (state == SETTLE) begin
                SampleData <= MuxData;
                SampleCh   <= Sel;
            end

            if (accept) begin
                count <= (Dwell == '0) ? DWELL_W'(1) : Dwell;
            end else if (state == DWELL && Enable && !Mode && count != '0) begin
                count <= count - DWELL_W'(1);
            end

            // A LastCh lowered below the current channel wraps on the next advance.
            if (advance) begin
                if (Sel >= LastCh) begin
                    Sel  <= '0;
                    Wrap <= 1'b1;
                end else begin
                    Sel <= Sel + CH_BITS'(1);
                end
            end
        end
    end

endmodule
